registro_universal: RTL and testbench

Parametrised universal register, the synchronous successor to the transparent D latch in this lab series. It holds a WIDTH-bit word and, under a 3-bit mode select, holds, shifts, rotates, runs a Johnson step, parallel-loads or clears on each enabled clock edge. A shift counter flags every completed WIDTH-bit serialisation, so the block can act as a serialiser/deserialiser in later exercises.

---
 rtl/registro_universal.sv | 65 ++++++
 tb/tb_registro_universal.sv | 130 +++++++++++++
 2 files changed

// File: rtl/registro_universal.sv
// registro_universal: universal shift/rotate/Johnson register with a serialisation step counter
module registro_universal #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [2:0]               mode,
    input  logic [WIDTH-1:0]         d,
    input  logic                     sin_r,
    input  logic                     sin_l,
    output logic [WIDTH-1:0]         q,
    output logic                     sout_r,
    output logic                     sout_l,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic             w_shift;
    logic             w_restart;
    // next word and step classification for the selected mode
    always_comb begin
        w_q_next  = r_q;
        w_shift   = 1'b0;
        w_restart = 1'b0;
        case (mode)
            3'b001: begin w_q_next = {sin_r, r_q[WIDTH-1:1]};  w_shift = 1'b1; end
            3'b010: begin w_q_next = {r_q[WIDTH-2:0], sin_l};  w_shift = 1'b1; end
            3'b011: begin w_q_next = d;                        w_restart = 1'b1; end
            3'b100: begin w_q_next = {r_q[0], r_q[WIDTH-1:1]}; w_shift = 1'b1; end
            3'b101: begin w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]}; w_shift = 1'b1; end
            3'b110: begin w_q_next = {~r_q[0], r_q[WIDTH-1:1]}; w_shift = 1'b1; end
            3'b111: begin w_q_next = '0;                       w_restart = 1'b1; end
            default: w_q_next = r_q;
        endcase
    end
    // register word, step counter and one-cycle wrap pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (enable) begin
            r_q    <= w_q_next;
            r_done <= w_shift && (r_cnt == LAST);
            if (w_shift)
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + ONE;
            else if (w_restart)
                r_cnt <= '0;
        end else begin
            r_done <= 1'b0;
        end
    end
    assign q      = r_q;
    assign sout_r = r_q[0];
    assign sout_l = r_q[WIDTH-1];
    assign cnt    = r_cnt;
    assign done   = r_done;
endmodule

// File: tb/tb_registro_universal.sv
// tb_registro_universal: randomized and directed check of registro_universal against an arithmetic model
module tb_registro_universal;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         rst, enable, sin_r, sin_l, sout_r, sout_l, done;
    logic [2:0]   mode;
    logic [W-1:0] d, q;
    logic [2:0]   cnt;
    int           n_checks = 0;
    int           n_fail = 0;
    int           m_q = 0;
    int           m_cnt = 0;
    int           m_done = 0;

    always #5 clk = ~clk;

    registro_universal #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .d(d),
        .sin_r(sin_r), .sin_l(sin_l), .q(q), .sout_r(sout_r), .sout_l(sout_l),
        .cnt(cnt), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input bit r, input bit e, input bit [2:0] m, input int dv, input int sr, input int sl);
        bit sh;
        sh = 1'b1;
        if (r) begin
            m_q = 0; m_cnt = 0; m_done = 0;
        end else if (!e) begin
            m_done = 0;
        end else begin
            case (m)
                3'd0: sh = 1'b0;
                3'd1: m_q = m_q / 2 + sr * 128;
                3'd2: m_q = (m_q * 2) % 256 + sl;
                3'd3: begin m_q = dv; m_cnt = 0; sh = 1'b0; end
                3'd4: m_q = m_q / 2 + (m_q % 2) * 128;
                3'd5: m_q = (m_q * 2) % 256 + m_q / 128;
                3'd6: m_q = m_q / 2 + (1 - m_q % 2) * 128;
                default: begin m_q = 0; m_cnt = 0; sh = 1'b0; end
            endcase
            if (sh) begin
                m_cnt = (m_cnt + 1) % W;
                m_done = (m_cnt == 0) ? 1 : 0;
            end else begin
                m_done = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input bit [2:0] m, input logic [W-1:0] dv, input bit sr, input bit sl);
        rst = r; enable = e; mode = m; d = dv; sin_r = sr; sin_l = sl;
        @(posedge clk);
        model(r, e, m, int'(dv), int'(sr), int'(sl));
        #1;
        chk("q", q, m_q);
        chk("cnt", cnt, m_cnt);
        chk("done", done, m_done);
        chk("sout_r", sout_r, m_q % 2);
        chk("sout_l", sout_l, m_q / 128);
    endtask

    initial begin
        logic [W-1:0] ser;
        logic [W-1:0] des;
        ser = 8'hA5;
        des = 8'b0101_0011;
        rst = 1'b1; enable = 1'b1; mode = 3'b011; d = 8'hFF; sin_r = 1'b0; sin_l = 1'b0;
        @(posedge clk); #1;
        step(1, 1, 3'b011, 8'hFF, 0, 0);
        chk("reset_q", q, 0);
        chk("reset_cnt", cnt, 0);
        chk("reset_done", done, 0);
        step(0, 1, 3'b011, 8'hA5, 0, 0);
        for (int i = 0; i < W; i++) begin
            chk("ser_bit", sout_r, ser[i]);
            step(0, 1, 3'b001, 8'h00, 0, 0);
        end
        chk("ser_q", q, 0);
        chk("ser_done", done, 1);
        step(0, 1, 3'b000, 8'h00, 0, 0);
        chk("ser_done_once", done, 0);
        step(0, 1, 3'b111, 8'h00, 0, 0);
        for (int i = 0; i < W; i++) step(0, 1, 3'b010, 8'h00, 0, des[i]);
        chk("des_q", q, 8'hCA);
        chk("des_done", done, 1);
        step(0, 1, 3'b011, 8'h81, 0, 0);
        step(0, 1, 3'b101, 8'h00, 0, 0);
        chk("rol_q", q, 8'h03);
        step(0, 1, 3'b100, 8'h00, 0, 0);
        step(0, 1, 3'b100, 8'h00, 0, 0);
        chk("ror_q", q, 8'hC0);
        step(0, 1, 3'b111, 8'h00, 0, 0);
        for (int k = 1; k <= 2 * W; k++) begin
            step(0, 1, 3'b110, 8'h00, 0, 0);
            if (k == 1) chk("john_first", q, 8'h80);
            if (k == W) begin chk("john_half", q, 8'hFF); chk("john_done1", done, 1); end
        end
        chk("john_end", q, 8'h00);
        chk("john_done2", done, 1);
        step(0, 1, 3'b011, 8'h0F, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 3'b001, 8'h00, 1, 0);
        chk("int_cnt5", cnt, 5);
        for (int i = 0; i < 3; i++) step(0, 0, 3'b001, 8'h00, 1, 0);
        chk("int_hold_cnt", cnt, 5);
        for (int i = 0; i < 3; i++) step(0, 1, 3'b001, 8'h00, 1, 0);
        chk("int_done", done, 1);
        step(0, 1, 3'b011, 8'h0F, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 3'b010, 8'h00, 0, 1);
        step(0, 1, 3'b011, 8'h3C, 0, 0);
        chk("int_load_cnt", cnt, 0);
        chk("int_load_done", done, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 3'b100, 8'h00, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 3'b000, 8'h00, 1, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 3'b001, 8'h00, 1, 1);
        chk("hold_cnt", cnt, 3);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 40) == 0, $urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)),
                 8'($urandom), 1'($urandom), 1'($urandom));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
